vga_write_arbiter: RTL and testbench
====================================

// Module: vga_write_arbiter
// PURPOSE
//  Shares the single pixel-write port (x, y, color, write) of vga_adapter among NREQ drawing requesters.
//  Holds off all writes until the background image has been drawn (VGA_SYNC), then grants requesters round-robin.
//  Contains a full-screen clear sequencer that takes priority over all requesters.
//  Sits between drawing engines/CPU framebuffer writes and vga_adapter's x/y/color/write inputs.
// PARAMETERS
//  RESOLUTION   "640x480"  "640x480" | "320x240" | "160x120"; sets W x H
//  COLOR_DEPTH  9          9 | 6 | 3 bits per pixel
//  nX           derived    10/9/8 x-coordinate bits for the three resolutions
//  nY           derived    9/8/7 y-coordinate bits for the three resolutions
//  NREQ         2          number of requesters, 1..8
// PORTS
//  clock        in   1                  system clock (CLOCK_50 at top)
//  resetn       in   1                  asynchronous, active-low reset
//  bg_done      in   1                  vga_adapter VGA_SYNC; background drawn
//  req_valid    in   NREQ               per-requester write request
//  req_x        in   NREQ*nX            packed x; requester i at [i*nX +: nX]
//  req_y        in   NREQ*nY            packed y; requester i at [i*nY +: nY]
//  req_color    in   NREQ*COLOR_DEPTH   packed color
//  req_ready    out  NREQ               one-hot grant; transfer when valid & ready
//  clear_start  in   1                  pulse: fill whole screen with clear_color
//  clear_color  in   COLOR_DEPTH        fill color, sampled with clear_start
//  vga_x        out  nX                 to vga_adapter .x
//  vga_y        out  nY                 to vga_adapter .y
//  vga_color    out  COLOR_DEPTH        to vga_adapter .color
//  vga_write    out  1                  to vga_adapter .write
//  busy         out  1                  high in WAIT_BG or CLEAR
//  clear_done   out  1                  one-cycle pulse after the last clear pixel
// BEHAVIOUR
//  Reset: state=WAIT_BG; all outputs 0; rr pointer=0; bg seen=0; clear pending=0; busy=1.
//  FSM states: WAIT_BG -> ARB when bg_done=1. bg_done is sticky: once seen, later drops are ignored.
//  FSM states: ARB -> CLEAR when clear is pending. CLEAR -> ARB after pixel (W-1,H-1) is written.
//  clear_start in any state sets pending and latches clear_color.
//  clear_start during CLEAR is ignored.
//  A clear pending in WAIT_BG starts on the first ARB cycle, with no requester grant on that cycle.
//  ARB: req_ready is combinational, set for at most one requester.
//  ARB grant: the first valid requester at or after the rr pointer, with wrap-around.
//  ARB, no valid requester: no grant and the pointer holds.
//  On a grant, the pointer moves to granted+1 mod NREQ.
//  On a grant, vga_x/y/color are registered; vga_write=1 on the next cycle (1-cycle latency).
//  ARB throughput: one write per cycle.
//  vga_write=0 on every cycle without a transfer. vga_x/y/color hold their last values.
//  CLEAR: req_ready=0. One pixel per cycle, row-major: x 0..W-1, then y++.
//  CLEAR: vga_write=1 for W*H consecutive cycles.
//  clear_done pulses on the cycle after the last pixel write; the FSM is in ARB on that cycle.
//  clear_done is never asserted together with a grant-generated write.
//  Async reset mid-clear or mid-write: immediate return to reset values. No partial pixel is written.
//  Width rule: clear counters are nX/nY wide. Compare against W-1/H-1; never rely on natural overflow.
// CONFIGURATION
//  `VGA_ARB_CLIP_EN defined: a granted request with x>=W or y>=H is accepted (ready=1).
//   No write is issued for it; vga_write stays 0.
//   clip_count (out, 16 bits) increments and saturates at 16'hFFFF.
//  `VGA_ARB_CLIP_EN undefined: no clip_count port. Out-of-range coordinates pass through unchanged.
// STRUCTURE
//  Shared include vga_params.vh: RESOLUTION->nX/nY/W/H mapping and the FSM state encodings.
//  FSM state encodings: WAIT_BG=2'd0, ARB=2'd1, CLEAR=2'd2.
//  Sub-module vga_rr_arbiter holds the pure combinational round-robin grant logic.
//  vga_rr_arbiter: req[NREQ], ptr -> one-hot gnt, gnt_idx. The FSM, registers and clear counters stay in the top.
// TESTING (RESOLUTION="160x120", COLOR_DEPTH=9, NREQ=2)
//  1. req_valid=2'b11 with bg_done=0 for 20 cycles -> req_ready=0, vga_write=0, busy=1.
//  2. Raise bg_done for one cycle, then drop it -> ARB is entered and stays; busy=0.
//  3. req_valid=2'b11 held for 4 cycles from pointer 0 -> grants 01,10,01,10.
//     vga_write=1 each following cycle, with the granted requester's x/y/color.
//  4. Only req1 valid, x=5 y=7 color=9'h1C0 -> ready=2'b10 the same cycle.
//     Next cycle: vga_x=5, vga_y=7, vga_color=9'h1C0, vga_write=1.
//  5. clear_start with clear_color=9'h000 -> 19200 consecutive writes from (0,0) to (159,119), req_ready=0.
//     Then clear_done pulses for one cycle and grants resume.
//  6. Deassert resetn at clear pixel (40,3) -> outputs 0 asynchronously.
//     After release: WAIT_BG and no clear pending.
//     With CLIP_EN: x=200 -> accepted, no write, clip_count=1.

Source files
------------

// File: rtl/vga_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vga_write_arbiter_pkg
// Purpose : shared definitions for the VGA pixel-write arbiter. This covers the
//           FSM state encoding and the mapping from resolution to coordinate
//           widths and screen size.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package vga_write_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_BG = 2'd0,
        ST_ARB     = 2'd1,
        ST_CLEAR   = 2'd2
    } state_t;

    // Resolution selector: 0 = 640x480, 1 = 320x240, 2 = 160x120
    function automatic int nx_of(input int sel);
        case (sel)
            1:       return 9;
            2:       return 8;
            default: return 10;
        endcase
    endfunction

    function automatic int ny_of(input int sel);
        case (sel)
            1:       return 8;
            2:       return 7;
            default: return 9;
        endcase
    endfunction

    function automatic int w_of(input int sel);
        case (sel)
            1:       return 320;
            2:       return 160;
            default: return 640;
        endcase
    endfunction

    function automatic int h_of(input int sel);
        case (sel)
            1:       return 240;
            2:       return 120;
            default: return 480;
        endcase
    endfunction

endpackage

// File: rtl/vga_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// vga_write_arbiter_if
// Purpose : requester-side bus of the VGA write arbiter. It carries NREQ packed
//           pixel requests and the one-hot ready grant that comes back.
// Signals : req_valid[NREQ], req_x[NREQ*nX], req_y[NREQ*nY],
//           req_color[NREQ*COLOR_DEPTH], req_ready[NREQ]
// Modports: master (drawing engines), slave (arbiter)
// -----------------------------------------------------------------------------
interface vga_write_arbiter_if #(
    parameter string RESOLUTION  = "640x480",
    parameter int    COLOR_DEPTH = 9,
    parameter int    NREQ        = 2
) ();
    import vga_write_arbiter_pkg::*;

    localparam int RES_SEL = (RESOLUTION == "320x240") ? 1 :
                             (RESOLUTION == "160x120") ? 2 : 0;
    localparam int NX = nx_of(RES_SEL);
    localparam int NY = ny_of(RES_SEL);

    logic [NREQ-1:0]             req_valid;
    logic [NREQ*NX-1:0]          req_x;
    logic [NREQ*NY-1:0]          req_y;
    logic [NREQ*COLOR_DEPTH-1:0] req_color;
    logic [NREQ-1:0]             req_ready;

    modport master (output req_valid, req_x, req_y, req_color, input req_ready);
    modport slave  (input req_valid, req_x, req_y, req_color, output req_ready);

endinterface

// File: rtl/vga_rr_arbiter.sv
// -----------------------------------------------------------------------------
// vga_rr_arbiter
// Purpose : purely combinational round-robin grant. The first asserted request
//           at or after ptr, wrapping around, wins.
// Ports   : req[NREQ] in, ptr[PW] in, gnt[NREQ] out (one-hot),
//           gnt_idx[PW] out, gnt_any out
// -----------------------------------------------------------------------------
module vga_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   gnt_idx,
    output logic            gnt_any
);

    // Scan from the pointer upward; the first hit locks out the rest
    always_comb begin
        gnt     = {NREQ{1'b0}};
        gnt_idx = {PW{1'b0}};
        gnt_any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            automatic int idx = (int'(ptr) + k) % NREQ;
            if (!gnt_any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = PW'(idx);
                gnt_any  = 1'b1;
            end else begin
                gnt_any = gnt_any;
            end
        end
    end

endmodule

// File: rtl/vga_write_arbiter.sv
// -----------------------------------------------------------------------------
// vga_write_arbiter
// Purpose : shares the vga_adapter pixel-write port among NREQ requesters.
//           Writes are held off until the background has been drawn. After
//           that, requesters are granted round-robin with one write per cycle.
//           A full-screen clear sequencer takes priority over all requesters.
// Ports   : clock, resetn (async active-low), bg_done, req_if (slave),
//           clear_start, clear_color, vga_x, vga_y, vga_color, vga_write,
//           busy, clear_done, clip_count (only with VGA_ARB_CLIP_EN)
// Config  : VGA_ARB_CLIP_EN - drop off-screen requests and count them
// -----------------------------------------------------------------------------
module vga_write_arbiter
    import vga_write_arbiter_pkg::*;
#(
    parameter string RESOLUTION  = "640x480",
    parameter int    COLOR_DEPTH = 9,
    parameter int    NREQ        = 2,
    localparam int   RES_SEL     = (RESOLUTION == "320x240") ? 1 :
                                   (RESOLUTION == "160x120") ? 2 : 0,
    localparam int   NX          = nx_of(RES_SEL),
    localparam int   NY          = ny_of(RES_SEL)
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   bg_done,
    vga_write_arbiter_if.slave     req_if,
    input  logic                   clear_start,
    input  logic [COLOR_DEPTH-1:0] clear_color,
    output logic [NX-1:0]          vga_x,
    output logic [NY-1:0]          vga_y,
    output logic [COLOR_DEPTH-1:0] vga_color,
    output logic                   vga_write,
    output logic                   busy,
    output logic                   clear_done
`ifdef VGA_ARB_CLIP_EN
    ,
    output logic [15:0]            clip_count
`endif
);

    localparam int            PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NX-1:0] X_LAST   = NX'(w_of(RES_SEL) - 1);
    localparam logic [NY-1:0] Y_LAST   = NY'(h_of(RES_SEL) - 1);
    localparam logic [NX-1:0] X_ONE    = {{(NX-1){1'b0}}, 1'b1};
    localparam logic [NY-1:0] Y_ONE    = {{(NY-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);
    localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};

    state_t                   r_state, w_next;
    logic [PW-1:0]            r_ptr;
    logic                     r_clr_pend, r_clr_last;
    logic [COLOR_DEPTH-1:0]   r_clr_color;
    logic [NX-1:0]            r_cx;
    logic [NY-1:0]            r_cy;
    logic [NX-1:0]            r_vga_x;
    logic [NY-1:0]            r_vga_y;
    logic [COLOR_DEPTH-1:0]   r_vga_color;
    logic                     r_vga_write, r_clear_done;

    logic                     w_grant_en, w_gnt_any, w_last_px, w_clr_accept, w_clip;
    logic [NREQ-1:0]          w_req, w_gnt;
    logic [PW-1:0]            w_gnt_idx;
    logic [NX-1:0]            w_sel_x;
    logic [NY-1:0]            w_sel_y;
    logic [COLOR_DEPTH-1:0]   w_sel_c;

    // Grants are blocked while a clear is pending (so the clear starts on the
    // next cycle) and on the cycle right after the clear. This keeps a
    // grant-generated write from landing on the clear_done cycle.
    assign w_grant_en   = (r_state == ST_ARB) && !r_clr_pend && !r_clr_last;
    assign w_req        = w_grant_en ? req_if.req_valid : {NREQ{1'b0}};
    assign w_last_px    = (r_cx == X_LAST) && (r_cy == Y_LAST);
    assign w_clr_accept = clear_start && (r_state != ST_CLEAR)
                          && !((r_state == ST_ARB) && r_clr_pend);

    vga_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .req     (w_req),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .gnt_any (w_gnt_any)
    );

    assign req_if.req_ready = w_gnt;

    // Pick out the granted requester's fields and flag off-screen coordinates
    always_comb begin
        w_sel_x = req_if.req_x[int'(w_gnt_idx)*NX +: NX];
        w_sel_y = req_if.req_y[int'(w_gnt_idx)*NY +: NY];
        w_sel_c = req_if.req_color[int'(w_gnt_idx)*COLOR_DEPTH +: COLOR_DEPTH];
`ifdef VGA_ARB_CLIP_EN
        w_clip  = (w_sel_x > X_LAST) || (w_sel_y > Y_LAST);
`else
        w_clip  = 1'b0;
`endif
    end

    // Next-state logic; WAIT_BG is never re-entered, which makes bg_done sticky
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_WAIT_BG: if (bg_done) w_next = ST_ARB; else w_next = ST_WAIT_BG;
            ST_ARB:     if (r_clr_pend) w_next = ST_CLEAR; else w_next = ST_ARB;
            ST_CLEAR:   if (w_last_px) w_next = ST_ARB; else w_next = ST_CLEAR;
            default:    w_next = ST_WAIT_BG;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= ST_WAIT_BG;
        else         r_state <= w_next;
    end

    // Round-robin pointer: moves past the winner, holds when nobody is granted
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)        r_ptr <= {PW{1'b0}};
        else if (w_gnt_any) r_ptr <= (w_gnt_idx == PTR_LAST) ? {PW{1'b0}} : w_gnt_idx + PTR_ONE;
        else                r_ptr <= r_ptr;
    end

    // Clear request latch, raster counters and the end-of-clear pulse pipeline
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_clr_pend   <= 1'b0;
            r_clr_color  <= {COLOR_DEPTH{1'b0}};
            r_cx         <= {NX{1'b0}};
            r_cy         <= {NY{1'b0}};
            r_clr_last   <= 1'b0;
            r_clear_done <= 1'b0;
        end else begin
            if (w_clr_accept) begin
                r_clr_pend  <= 1'b1;
                r_clr_color <= clear_color;
            end else if ((r_state == ST_ARB) && r_clr_pend) begin
                r_clr_pend  <= 1'b0;
            end else begin
                r_clr_pend  <= r_clr_pend;
            end
            if (r_state == ST_CLEAR) begin
                if (r_cx == X_LAST) begin
                    r_cx <= {NX{1'b0}};
                    r_cy <= (r_cy == Y_LAST) ? {NY{1'b0}} : r_cy + Y_ONE;
                end else begin
                    r_cx <= r_cx + X_ONE;
                end
            end else begin
                r_cx <= {NX{1'b0}};
                r_cy <= {NY{1'b0}};
            end
            r_clr_last   <= (r_state == ST_CLEAR) && w_last_px;
            r_clear_done <= r_clr_last;
        end
    end

    // Pixel port registers; coordinates and color hold when nothing is written
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_vga_x     <= {NX{1'b0}};
            r_vga_y     <= {NY{1'b0}};
            r_vga_color <= {COLOR_DEPTH{1'b0}};
            r_vga_write <= 1'b0;
        end else if (r_state == ST_CLEAR) begin
            r_vga_x     <= r_cx;
            r_vga_y     <= r_cy;
            r_vga_color <= r_clr_color;
            r_vga_write <= 1'b1;
        end else if (w_gnt_any && !w_clip) begin
            r_vga_x     <= w_sel_x;
            r_vga_y     <= w_sel_y;
            r_vga_color <= w_sel_c;
            r_vga_write <= 1'b1;
        end else begin
            r_vga_write <= 1'b0;
        end
    end

`ifdef VGA_ARB_CLIP_EN
    logic [15:0] r_clip_count;

    // Saturating count of accepted-but-dropped off-screen requests
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)                                    r_clip_count <= 16'h0000;
        else if (w_gnt_any && w_clip && (r_clip_count != 16'hFFFF)) r_clip_count <= r_clip_count + 16'h0001;
        else                                            r_clip_count <= r_clip_count;
    end

    assign clip_count = r_clip_count;
`endif

    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_color  = r_vga_color;
    assign vga_write  = r_vga_write;
    assign clear_done = r_clear_done;
    assign busy       = (r_state != ST_ARB);

endmodule

// File: tb/tb_vga_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_write_arbiter
// Scoreboard bench for vga_write_arbiter at 160x120, 9-bit color, 2 requesters.
// Expected pixel writes are queued with the cycle they must appear on; a
// negedge monitor compares vga_write, vga_x/y/color and clear_done every cycle.
// Build with VGA_ARB_CLIP_EN defined to also exercise the clip counter.
// -----------------------------------------------------------------------------
module tb_vga_write_arbiter;

    localparam int NPIX = 160 * 120;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [8:0] c;
        int         due;
    } exp_t;

    logic       clock = 1'b0;
    logic       resetn, bg_done, clear_start;
    logic [8:0] clear_color;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [8:0] vga_color;
    logic       vga_write, busy, clear_done;
`ifdef VGA_ARB_CLIP_EN
    logic [15:0] clip_count;
`endif

    exp_t sb[$];
    exp_t mon_e;
    logic mon_w;
    int   cyc = 0, done_due = -1, n_cmp = 0, n_err = 0, m_ptr = 0, n0 = 0;
    bit   mon_en = 1'b0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    vga_write_arbiter_if #(.RESOLUTION("160x120"), .COLOR_DEPTH(9), .NREQ(2)) rif ();

    vga_write_arbiter #(.RESOLUTION("160x120"), .COLOR_DEPTH(9), .NREQ(2)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .bg_done     (bg_done),
        .req_if      (rif.slave),
        .clear_start (clear_start),
        .clear_color (clear_color),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_color   (vga_color),
        .vga_write   (vga_write),
        .busy        (busy),
        .clear_done  (clear_done)
`ifdef VGA_ARB_CLIP_EN
        ,
        .clip_count  (clip_count)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] x, input logic [6:0] y, input logic [8:0] c);
        rif.req_x[i*8 +: 8]     = x;
        rif.req_y[i*7 +: 7]     = y;
        rif.req_color[i*9 +: 9] = c;
    endtask

    // One arbitration cycle: model the round-robin winner, queue its pixel
    task automatic arb_cycle(input logic [1:0] v);
        int g;
        g = -1;
        rif.req_valid = v;
        for (int k = 0; k < 2; k++)
            if (g < 0 && v[(m_ptr + k) % 2]) g = (m_ptr + k) % 2;
        if (g >= 0) begin
            sb.push_back('{rif.req_x[g*8 +: 8], rif.req_y[g*7 +: 7], rif.req_color[g*9 +: 9], cyc + 1});
            m_ptr = (g + 1) % 2;
        end
        @(negedge clock);
        check_eq("req_ready", {30'd0, rif.req_ready}, (g < 0) ? 32'd0 : (32'd1 << g));
        @(posedge clock); #1;
    endtask

    // Output monitor: every cycle the write strobe, data and clear_done must match
    always @(negedge clock) begin
        if (mon_en) begin
            mon_w = (sb.size() > 0) && (sb[0].due == cyc);
            check_eq("vga_write", {31'd0, vga_write}, {31'd0, mon_w});
            if (mon_w) begin
                mon_e = sb.pop_front();
                check_eq("vga_x", {24'd0, vga_x}, {24'd0, mon_e.x});
                check_eq("vga_y", {25'd0, vga_y}, {25'd0, mon_e.y});
                check_eq("vga_color", {23'd0, vga_color}, {23'd0, mon_e.c});
            end
            check_eq("clear_done", {31'd0, clear_done}, {31'd0, (cyc == done_due)});
        end
    end

    initial begin
        resetn = 1'b0; bg_done = 1'b0; clear_start = 1'b0; clear_color = 9'h000;
        rif.req_valid = 2'b00; rif.req_x = 16'h0000; rif.req_y = 14'h0000; rif.req_color = 18'h00000;
        #1;
        check_eq("rst_write", {31'd0, vga_write}, 32'd0);
        check_eq("rst_x", {24'd0, vga_x}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd1);
        check_eq("rst_done", {31'd0, clear_done}, 32'd0);
        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;
        mon_en = 1'b1;

        // 1: requests before the background is drawn are held off
        set_req(0, 8'd1, 7'd2, 9'h003); set_req(1, 8'd4, 7'd5, 9'h006);
        rif.req_valid = 2'b11;
        repeat (20) begin
            @(negedge clock);
            check_eq("wait_ready", {30'd0, rif.req_ready}, 32'd0);
            check_eq("wait_busy", {31'd0, busy}, 32'd1);
            @(posedge clock); #1;
        end

        // 2: one-cycle bg_done pulse is enough to reach ARB permanently
        rif.req_valid = 2'b00; bg_done = 1'b1;
        @(posedge clock); #1 bg_done = 1'b0;
        repeat (5) begin
            @(negedge clock);
            check_eq("arb_busy", {31'd0, busy}, 32'd0);
            @(posedge clock); #1;
        end

        // 3: both requesting from pointer 0 alternates 01,10,01,10
        for (int i = 0; i < 4; i++) begin
            set_req(0, 8'(10 * i), 7'(i + 1), 9'(9'h100 + i));
            set_req(1, 8'(150 - i), 7'(100 + i), 9'(9'h055 + 3 * i));
            arb_cycle(2'b11);
        end
        // no request: pointer holds
        arb_cycle(2'b00); arb_cycle(2'b00);
        // 4: only req1
        set_req(1, 8'd5, 7'd7, 9'h1C0);
        arb_cycle(2'b10);
        // wrap-around from pointer 1 back to requester 0
        set_req(0, 8'd159, 7'd119, 9'h1FF);
        arb_cycle(2'b01);
        set_req(0, 8'd0, 7'd0, 9'h0AA);
        arb_cycle(2'b01);
        // random traffic
        repeat (40) begin
            set_req(0, 8'($urandom_range(159)), 7'($urandom_range(119)), 9'($urandom_range(511)));
            set_req(1, 8'($urandom_range(159)), 7'($urandom_range(119)), 9'($urandom_range(511)));
            arb_cycle(2'($urandom_range(3)));
        end

        // 5: full-screen clear, requesters locked out, then clear_done and grants resume
        rif.req_valid = 2'b00; clear_start = 1'b1; clear_color = 9'h000;
        n0 = cyc;
        for (int k = 0; k < NPIX; k++) sb.push_back('{8'(k % 160), 7'(k / 160), 9'h000, n0 + 3 + k});
        done_due = n0 + 3 + NPIX;
        @(posedge clock); #1;
        clear_start = 1'b0; clear_color = 9'h0F0; rif.req_valid = 2'b11;
        while (cyc < done_due) begin
            @(negedge clock);
            check_eq("clr_ready", {30'd0, rif.req_ready}, 32'd0);
            check_eq("clr_busy", {31'd0, busy}, {31'd0, (cyc >= n0 + 2) && (cyc < n0 + 2 + NPIX)});
            @(posedge clock); #1;
        end
        repeat (4) arb_cycle(2'b11);

        // 6: async reset in the middle of a clear at pixel (40,3)
        rif.req_valid = 2'b00; clear_start = 1'b1; clear_color = 9'h1FF;
        n0 = cyc;
        for (int k = 0; k <= 3 * 160 + 40; k++) sb.push_back('{8'(k % 160), 7'(k / 160), 9'h1FF, n0 + 3 + k});
        @(posedge clock); #1 clear_start = 1'b0;
        while (cyc < n0 + 3 + 3 * 160 + 40) begin
            @(posedge clock); #1;
        end
        @(negedge clock); #1;
        check_eq("pre_rst_drained", sb.size(), 32'd0);
        mon_en = 1'b0;
        resetn = 1'b0;
        #1;
        check_eq("arst_write", {31'd0, vga_write}, 32'd0);
        check_eq("arst_x", {24'd0, vga_x}, 32'd0);
        check_eq("arst_y", {25'd0, vga_y}, 32'd0);
        check_eq("arst_color", {23'd0, vga_color}, 32'd0);
        check_eq("arst_busy", {31'd0, busy}, 32'd1);
        sb.delete();
        done_due = -1;
        m_ptr = 0;
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;
        mon_en = 1'b1;
        rif.req_valid = 2'b11;
        repeat (5) begin
            @(negedge clock);
            check_eq("rewait_ready", {30'd0, rif.req_ready}, 32'd0);
            check_eq("rewait_busy", {31'd0, busy}, 32'd1);
            @(posedge clock); #1;
        end
        rif.req_valid = 2'b00; bg_done = 1'b1;
        @(posedge clock); #1 bg_done = 1'b0;
        // a stale pending clear would block this first grant
        set_req(0, 8'd33, 7'd44, 9'h123); set_req(1, 8'd55, 7'd66, 9'h0321 >> 1);
        repeat (6) arb_cycle(2'b11);

`ifdef VGA_ARB_CLIP_EN
        set_req(0, 8'd200, 7'd10, 9'h005);
        rif.req_valid = 2'b01;
        @(negedge clock);
        check_eq("clip_ready", {30'd0, rif.req_ready}, 32'd1);
        m_ptr = 1;
        @(posedge clock); #1 rif.req_valid = 2'b00;
        check_eq("clip_count", {16'd0, clip_count}, 32'd1);
        arb_cycle(2'b00);
`endif

        rif.req_valid = 2'b00;
        repeat (3) @(posedge clock);
        #1 check_eq("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
